// File: rtl/mul_div_pkg.sv
// -----------------------------------------------------------------------------
// mul_div_pkg
// Shared definitions for the multi-channel multiply-then-divide stage:
//   - default channel count and sample/multiplier widths
//   - helpers deriving the numerator width (NW) and pipeline latency (L)
//   - rounding-mode encoding carried with each input beat
// -----------------------------------------------------------------------------
package mul_div_pkg;

  localparam int CH_DEF = 3;
  localparam int DW_DEF = 8;
  localparam int MW_DEF = 8;

  typedef enum logic {
    ROUND_TRUNC   = 1'b0,
    ROUND_HALF_UP = 1'b1
  } round_mode_e;

  // pix*mul + (div>>1) always fits in DW+MW bits.
  function automatic int calc_nw(input int dw, input int mw);
    return dw + mw;
  endfunction

  // Stage M + NW divider stages + stage C.
  function automatic int calc_lat(input int dw, input int mw);
    return calc_nw(dw, mw) + 2;
  endfunction

endpackage

// File: rtl/mul_div_ch_div_pipe.sv
// -----------------------------------------------------------------------------
// div_pipe
// One channel's NW-stage pipelined restoring divider, one quotient bit per
// stage, MSB first. The remainder is discarded. A sideband (bypass flag,
// zero-divisor flag, original sample) travels alongside so it lines up with
// the quotient at the output.
//
// Ports:
//   clk        clock
//   en         pipeline enable; all stages hold when low
//   num        NW-bit numerator
//   den        MW-bit divisor
//   bypass     sideband: channel bypass flag
//   zero       sideband: divisor was zero
//   pix        sideband: original sample
//   quo        NW-bit quotient, NW cycles after num/den
//   out_*      sideband delayed by NW cycles
// -----------------------------------------------------------------------------
module div_pipe
  import mul_div_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int MW = MW_DEF,
  parameter int NW = calc_nw(DW, MW)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [NW-1:0] num,
  input  logic [MW-1:0] den,
  input  logic          bypass,
  input  logic          zero,
  input  logic [DW-1:0] pix,
  output logic [NW-1:0] quo,
  output logic          out_bypass,
  output logic          out_zero,
  output logic [DW-1:0] out_pix
);

  // s_* : inputs of stage i (stage 0 fed from ports, stage i from register i-1)
  // r_* : registered outputs of stage i
  logic [MW-1:0] s_rem [NW];
  logic [NW-1:0] s_num [NW];
  logic [NW-1:0] s_quo [NW];
  logic [MW-1:0] s_den [NW];
  logic          s_byp [NW];
  logic          s_zero[NW];
  logic [DW-1:0] s_pix [NW];

  logic [MW-1:0] r_rem [NW];
  logic [NW-1:0] r_num [NW];
  logic [NW-1:0] r_quo [NW];
  logic [MW-1:0] r_den [NW];
  logic          r_byp [NW];
  logic          r_zero[NW];
  logic [DW-1:0] r_pix [NW];

  logic [MW:0]   trial [NW];
  logic [MW:0]   diff  [NW];
  logic          take  [NW];
  logic [MW-1:0] nx_rem[NW];
  logic [NW-1:0] nx_num[NW];
  logic [NW-1:0] nx_quo[NW];

  // NOTE: every always_comb output is assigned unconditionally on every pass,
  // so no latch can be inferred.
  always_comb begin
    s_rem[0]  = '0;
    s_num[0]  = num;
    s_quo[0]  = '0;
    s_den[0]  = den;
    s_byp[0]  = bypass;
    s_zero[0] = zero;
    s_pix[0]  = pix;
    for (int i = 1; i < NW; i++) begin
      s_rem[i]  = r_rem[i-1];
      s_num[i]  = r_num[i-1];
      s_quo[i]  = r_quo[i-1];
      s_den[i]  = r_den[i-1];
      s_byp[i]  = r_byp[i-1];
      s_zero[i] = r_zero[i-1];
      s_pix[i]  = r_pix[i-1];
    end
  end

  // Shift the next numerator bit into the partial remainder; subtract the
  // divisor when it fits. Remainder stays < den, so MW bits suffice and the
  // trial value needs one extra bit. With den = 0 the result is garbage, but
  // the zero flag overrides it downstream.
  always_comb begin
    for (int i = 0; i < NW; i++) begin
      trial[i]  = {s_rem[i], s_num[i][NW-1]};
      diff[i]   = trial[i] - {1'b0, s_den[i]};
      take[i]   = (trial[i] >= {1'b0, s_den[i]});
      nx_rem[i] = take[i] ? diff[i][MW-1:0] : trial[i][MW-1:0];
      nx_num[i] = {s_num[i][NW-2:0], 1'b0};
      nx_quo[i] = {s_quo[i][NW-2:0], take[i]};
    end
  end

  // NOTE: datapath registers carry no reset; only the valid chain in the top
  // level needs a defined reset state, and stale data behind valid = 0 is
  // never observed.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < NW; i++) begin
        r_rem[i]  <= nx_rem[i];
        r_num[i]  <= nx_num[i];
        r_quo[i]  <= nx_quo[i];
        r_den[i]  <= s_den[i];
        r_byp[i]  <= s_byp[i];
        r_zero[i] <= s_zero[i];
        r_pix[i]  <= s_pix[i];
      end
    end
  end

  assign quo        = r_quo[NW-1];
  assign out_bypass = r_byp[NW-1];
  assign out_zero   = r_zero[NW-1];
  assign out_pix    = r_pix[NW-1];

endmodule

// File: rtl/mul_div_ch.sv
// -----------------------------------------------------------------------------
// mul_div_ch
// Multi-channel round(pix*mul/div) with saturation and per-channel bypass,
// behind a stallable valid/ready pipeline of latency NW+2.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   in_valid / in_ready   input handshake (in_ready = global enable)
//   in_data               CH samples, channel k at [k*DW +: DW]
//   in_mul, in_div        per-channel multiplier / divisor, MW bits each
//   in_bypass             per-channel bypass (1 = pass sample unchanged)
//   in_round              0 = truncate, 1 = round half up
//   out_valid / out_ready output handshake
//   out_data              CH results, same packing as in_data
// -----------------------------------------------------------------------------
module mul_div_ch
  import mul_div_pkg::*;
#(
  parameter int CH = CH_DEF,
  parameter int DW = DW_DEF,
  parameter int MW = MW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CH*DW-1:0] in_data,
  input  logic [CH*MW-1:0] in_mul,
  input  logic [CH*MW-1:0] in_div,
  input  logic [CH-1:0]    in_bypass,
  input  logic             in_round,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CH*DW-1:0] out_data
);

  localparam int NW = calc_nw(DW, MW);

  // Whole pipeline advances together; a held output freezes every stage.
  logic en;
  logic accept;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign accept   = in_valid && in_ready;

  // ---------------- Stage M: multiply and optional half-divisor bias -------
  logic [NW-1:0] mc_num [CH];

  always_comb begin
    for (int k = 0; k < CH; k++) begin
      mc_num[k] = NW'(in_data[k*DW +: DW]) * NW'(in_mul[k*MW +: MW]);
      if (round_mode_e'(in_round) == ROUND_HALF_UP && in_div[k*MW +: MW] != '0)
        mc_num[k] = mc_num[k] + NW'(in_div[k*MW +: MW] >> 1);
    end
  end

  logic          m_valid;
  logic [NW-1:0] m_num  [CH];
  logic [MW-1:0] m_den  [CH];
  logic          m_byp  [CH];
  logic          m_zero [CH];
  logic [DW-1:0] m_pix  [CH];

  // NOTE: state registers use non-blocking assignments so every stage samples
  // its predecessor's pre-edge value.
  always_ff @(posedge clk) begin
    if (rst)
      m_valid <= 1'b0;
    else if (en)
      m_valid <= accept;
  end

  always_ff @(posedge clk) begin
    if (en) begin
      for (int k = 0; k < CH; k++) begin
        m_num[k]  <= mc_num[k];
        m_den[k]  <= in_div[k*MW +: MW];
        m_byp[k]  <= in_bypass[k];
        m_zero[k] <= (in_div[k*MW +: MW] == '0);
        m_pix[k]  <= in_data[k*DW +: DW];
      end
    end
  end

  // ---------------- Stage D: per-channel divider pipelines -----------------
  logic [NW-1:0] d_valid;
  logic [NW-1:0] d_quo  [CH];
  logic          d_byp  [CH];
  logic          d_zero [CH];
  logic [DW-1:0] d_pix  [CH];

  always_ff @(posedge clk) begin
    if (rst)
      d_valid <= '0;
    else if (en)
      d_valid <= {d_valid[NW-2:0], m_valid};
  end

  for (genvar k = 0; k < CH; k++) begin : g_ch
    div_pipe #(
      .DW (DW),
      .MW (MW),
      .NW (NW)
    ) u_div (
      .clk        (clk),
      .en         (en),
      .num        (m_num[k]),
      .den        (m_den[k]),
      .bypass     (m_byp[k]),
      .zero       (m_zero[k]),
      .pix        (m_pix[k]),
      .quo        (d_quo[k]),
      .out_bypass (d_byp[k]),
      .out_zero   (d_zero[k]),
      .out_pix    (d_pix[k])
    );
  end

  // ---------------- Stage C: bypass, zero-divisor and clip -----------------
  logic [CH*DW-1:0] c_data;

  always_comb begin
    c_data = '0;
    for (int k = 0; k < CH; k++) begin
      if (d_byp[k])
        c_data[k*DW +: DW] = d_pix[k];
      else if (d_zero[k] || (|d_quo[k][NW-1:DW]))
        c_data[k*DW +: DW] = '1;
      else
        c_data[k*DW +: DW] = d_quo[k][DW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (en) begin
      out_valid <= d_valid[NW-1];
      out_data  <= c_data;
    end
  end

endmodule

// File: doc/mul_div_ch.md
# mul_div_ch

Parametrised multiply-then-divide stage for multi-channel pixels; successor of the fixed 3×8-bit RGB scaler used in histogram equalisation and white-balance paths. Each channel computes round(pix·mul/div) with saturation, or passes through unchanged when its bypass bit is set. The block sits between the pixel source and the output formatter. Unlike its predecessor, it supports any channel count and widths, per-beat rounding mode, divide-by-zero handling and valid/ready backpressure through a stallable pipeline.

## Interface
- CH, 3, number of channels
- DW, 8, bits per channel sample
- MW, 8, bits per multiplier and per divisor
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_data  in  CH·DW  samples; channel k at [k·DW +: DW]
- in_mul  in  CH·MW  per-channel multiplier, same packing
- in_div  in  CH·MW  per-channel divisor, same packing
- in_bypass  in  CH  per-channel bypass; 1 = pass sample unchanged
- in_round  in  1  0 = truncate, 1 = round half up
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_data  out  CH·DW  results, same packing as in_data

## Operation
- A beat transfers when in_valid && in_ready. All side inputs (mul, div, bypass, round) are sampled with that beat and travel with it; no configuration state is held.
- Stage M (1 cycle), per channel:
  - P = pix·mul, width NW = DW+MW.
  - When in_round = 1 and div ≠ 0, N = P + (div>>1); otherwise N = P.
  - N never overflows NW bits, because (2^DW−1)(2^MW−1) + (2^MW−1)/2 < 2^NW.
- Stage D (NW cycles): pipelined restoring divider producing one quotient bit per stage, MSB first.
  - Quotient width is NW.
  - Remainder is discarded.
- Stage C (1 cycle):
  - Quotient ≥ 2^DW clips to 2^DW−1.
  - div = 0 with bypass = 0 yields 2^DW−1.
  - A bypassed channel outputs its original sample, carried alongside the divider pipeline.
- Channels are fully independent. Bypass and zero-divisor handling are per channel within the same beat.
- Stall rule: global enable en = !out_valid || out_ready. When en = 0, every pipeline register holds, including valid bits and carried data. in_ready = en.
- Bubbles propagate as valid = 0 slots. Data registers may update under en regardless of valid.

## Timing
- Latency L = NW + 2 cycles from accepted beat to out_valid, with no stalls. Default NW = 16, so L = 18.
- Throughput is one beat per cycle while out_ready = 1.
- A stall of S cycles delays every in-flight beat by exactly S cycles. Beats are never dropped, duplicated or reordered.
- out_data is registered and stable while out_valid && !out_ready.
- Reset: all valid bits are 0 and out_data = 0 on the cycle after rst. in_ready = 1 in reset and after reset.
- Reset mid-stream discards all in-flight beats. The first beat after reset sees an empty pipeline.
- in_ready is combinational from out_ready: no skid buffer, and the upstream must tolerate this path.

## Structure
- Package mul_div_pkg holds:
  - the default CH/DW/MW;
  - the function computing NW and L;
  - the round-mode encoding (ROUND_TRUNC = 0, ROUND_HALF_UP = 1).
- Sub-module div_pipe: one channel's NW-stage restoring divider with enable input, numerator NW bits, divisor MW bits, quotient NW bits, plus a carry-through sideband (bypass flag, zero flag, original sample). Instantiated CH times by a generate loop.
- The top level holds stage M, stage C, the valid chain and the handshake logic.

## Test plan
- Defaults, round = 0: pix {200,100,50}, mul {3,2,1}, div {4,3,1}, bypass 0 -> {150,66,50} after 18 cycles.
- Round = 1: pix 100, mul 2, div 3 -> 67. Pix 5, mul 1, div 2 -> 3. Same with round = 0 -> 66 and 2.
- Clip and zero divisor: pix 255, mul 255, div 1 -> 255. Div 0 -> 255. Bypass = 1 with div 0, pix 77 -> 77.
- Backpressure: stream 40 beats with random in_valid and out_ready toggling at 50% -> output sequence matches the reference model exactly. out_data is held while out_ready = 0.
- Reset at cycle 10 of a continuous stream -> no out_valid for 18 cycles after the restart beat, and no stale beat emerges.
- Parameter sweep CH = 4, DW = 10, MW = 12 -> L = 24. Random vectors match the model, including pix 1023, mul 4095, div 1 clipping to 1023.
